note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Sequential playback engine for song duration tables.
- Walks a note index from 0 upward and presents it to an external combinational duration table that returns microseconds.
- Holds each note for the requested time, derived from CLOCK_FREQ, then advances.
- Supports start/stop/pause, looping and end-of-song detection, and drives pitch lookup and tone generation downstream.

Parameters:
CLOCK_FREQ, 100_000_000, system clock in Hz; must be an integer multiple of 1_000_000 and at least 1_000_000
IDX_W, 11, note index width
DUR_US_W, 24, duration width in microseconds (max about 16.7 s)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin playback from index 0; honoured only in IDLE
stop  in  1  abort playback to IDLE; overrides all other inputs
pause  in  1  level; freezes playback while high
loop_en  in  1  level; restart at index 0 at end of song
speed  in  2  0=1x, 1=2x, 2=0.5x, 3=1x; sampled in LOAD
dur_us  in  DUR_US_W  duration of note_index from the table; 0 marks end of song
note_index  out  IDX_W  current table index
note_active  out  1  high while a note is timing (PLAY or PAUSED)
note_start  out  1  one-cycle pulse when a note begins
done  out  1  one-cycle pulse at song end (non-loop)
busy  out  1  high in every state except IDLE

Behaviour:
- Definitions:
  - CYC_US = CLOCK_FREQ/1_000_000.
  - Prescaler counts 0..P-1, with P = CYC_US, or 2*CYC_US when speed=0.5x.
  - Each prescaler wrap is one tick.
- Reset (rst_n low, async): state=IDLE; note_index=0; all 1-bit outputs 0; counters 0.
- States: IDLE, LOAD, PLAY, PAUSED, DONE.
- IDLE:
  - start=1 -> LOAD, with note_index=0.
- LOAD (exactly 1 cycle per note):
  - If dur_us!=0: latch remain=dur_us and speed, clear prescaler, pulse note_start, -> PLAY.
  - If dur_us==0 and note_index==0: -> DONE. An empty table never loops.
  - If dur_us==0, note_index!=0 and loop_en=1: note_index=0, stay LOAD.
  - If dur_us==0, note_index!=0 and loop_en=0: -> DONE.
- PLAY:
  - Prescaler increments each cycle.
  - On each tick, remain decrements by 1, or by 2 at 2x, saturating at 0.
  - On the cycle remain reaches 0: note_index+1, -> LOAD.
  - PLAY duration: dur_us*CYC_US cycles at 1x; ceil(dur_us/2)*CYC_US at 2x; dur_us*2*CYC_US at 0.5x.
- Index wrap:
  - Advancing from index 2^IDX_W-1 is treated as end of song.
  - Honours loop_en: loop_en=1 -> LOAD with index 0; loop_en=0 -> DONE with index unchanged.
- PAUSED:
  - pause=1 in PLAY -> PAUSED on the next edge; prescaler and remain are held.
  - pause=0 -> PLAY, continuing from the held count.
  - pause has no effect in IDLE, LOAD or DONE.
  - If pause and tick coincide, the tick is not applied and is taken after resume. Net note time = PLAY time plus paused cycles.
- DONE:
  - done=1 for 1 cycle, -> IDLE.
  - note_index holds its last value until the next start.
- stop=1 in any state -> IDLE on the next edge:
  - note_index=0, counters cleared, no done pulse.
  - stop has priority over start.
- note_active is combinational from state. note_start and done are registered pulses.
- Back-to-back notes: exactly one LOAD cycle with note_active=0 between notes.

Optional Feature:
NOTE_SEQ_SPEED_EN
- Defined: speed port is decoded as described above.
- Undefined:
  - speed is ignored and playback is always 1x.
  - Prescaler width is reduced to cover CYC_US only.
  - The port remains present.

Test Plan:
- CLOCK_FREQ=4_000_000, table {3,5,0}, start -> note_start at index 0; 12 PLAY cycles; 1 LOAD; index 1 for 20 PLAY cycles; done pulse; busy falls the cycle after done.
- Same table with loop_en=1 -> index sequence 0,1,0,1; no done pulse; stop -> IDLE with note_index=0 the next cycle.
- Table {0}, start -> DONE immediately with one done pulse and no note_start, including when loop_en=1.
- Table {4,0}, pause high for 7 cycles starting 5 cycles into note 0 -> note_active high for 16+7=23 cycles.
- With NOTE_SEQ_SPEED_EN: speed=1, dur 5 -> 12 PLAY cycles; speed=2, dur 3 -> 24 PLAY cycles. Without the macro, both give 1x timing.
- Assert rst_n low mid-PLAY -> all outputs 0 asynchronously; after release, start replays from index 0.

Source files
------------

// File: rtl/note_sequencer.sv
// ============================================================================
// Module   : note_sequencer
// Purpose  : Playback engine for a song duration table. Walks note_index
//            from 0, reads each note's duration (microseconds) from an
//            external combinational table, holds the note for that time and
//            then moves on. Supports start/stop/pause, looping and
//            end-of-song detection.
// Ports    : clk, rst_n            - clock, async active-low reset
//            start, stop           - begin from index 0 / abort to IDLE
//            pause, loop_en        - level controls
//            speed[1:0]            - 0=1x 1=2x 2=0.5x 3=1x (sampled in LOAD)
//            dur_us                - table duration for note_index, 0 = end
//            note_index            - current table index
//            note_active           - high while a note is timing
//            note_start, done      - one-cycle pulses
//            busy                  - high in any state but IDLE
// Macro    : NOTE_SEQ_SPEED_EN - when defined, the speed port is decoded;
//            otherwise playback is always 1x and speed is ignored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_sequencer #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int IDX_W      = 11,
    parameter int DUR_US_W   = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    input  logic                loop_en,
    input  logic [1:0]          speed,
    input  logic [DUR_US_W-1:0] dur_us,
    output logic [IDX_W-1:0]    note_index,
    output logic                note_active,
    output logic                note_start,
    output logic                done,
    output logic                busy
);

    localparam int CYC_US = CLOCK_FREQ / 1_000_000;
`ifdef NOTE_SEQ_SPEED_EN
    localparam int P_MAX  = 2 * CYC_US;
`else
    localparam int P_MAX  = CYC_US;
`endif
    // At least one bit so a 1 MHz clock still has a legal counter.
    localparam int PRE_W  = (P_MAX > 1) ? $clog2(P_MAX) : 1;

    localparam logic [PRE_W-1:0] C_LAST_1X = PRE_W'(CYC_US - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_PLAY   = 3'd2,
        S_PAUSED = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [PRE_W-1:0]    presc_q;
    logic [DUR_US_W-1:0] remain_q;
    logic                note_start_q;
    logic                done_q;

    logic [PRE_W-1:0]    presc_last;
    logic [DUR_US_W-1:0] dec;
    logic                tick;
    logic                note_end;
    logic [DUR_US_W-1:0] remain_d;

`ifdef NOTE_SEQ_SPEED_EN
    logic [1:0] speed_q;

    // 0.5x doubles the prescaler period; 2x doubles the per-tick step.
    always_comb begin
        presc_last = (speed_q == 2'd2) ? PRE_W'(2 * CYC_US - 1) : C_LAST_1X;
        dec        = (speed_q == 2'd1) ? DUR_US_W'(2) : DUR_US_W'(1);
    end
`else
    logic unused_speed;
    assign unused_speed = ^speed;

    always_comb begin
        presc_last = C_LAST_1X;
        dec        = DUR_US_W'(1);
    end
`endif

    assign tick     = (presc_q == presc_last);
    // Saturating decrement: the note ends on the tick that takes remain to 0.
    assign note_end = tick && (remain_q <= dec);
    assign remain_d = (remain_q <= dec) ? '0 : (remain_q - dec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            presc_q      <= '0;
            remain_q     <= '0;
            note_start_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef NOTE_SEQ_SPEED_EN
            speed_q      <= 2'd0;
`endif
        end else begin
            note_start_q <= 1'b0;
            done_q       <= 1'b0;
            if (stop) begin
                state_q  <= S_IDLE;
                idx_q    <= '0;
                presc_q  <= '0;
                remain_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q <= S_LOAD;
                            idx_q   <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (dur_us != '0) begin
                            remain_q     <= dur_us;
`ifdef NOTE_SEQ_SPEED_EN
                            speed_q      <= speed;
`endif
                            presc_q      <= '0;
                            note_start_q <= 1'b1;
                            state_q      <= S_PLAY;
                        end else if ((idx_q == '0) || !loop_en) begin
                            // Empty table never loops.
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= '0;
                        end
                    end
                    S_PLAY, S_PAUSED: begin
                        // Any cycle with pause high is frozen; the first
                        // cycle with pause low already advances the count.
                        if (pause) begin
                            state_q <= S_PAUSED;
                        end else begin
                            state_q <= S_PLAY;
                            if (tick) begin
                                presc_q  <= '0;
                                remain_q <= remain_d;
                                if (note_end) begin
                                    if (idx_q != '1) begin
                                        idx_q   <= idx_q + IDX_W'(1);
                                        state_q <= S_LOAD;
                                    end else if (loop_en) begin
                                        idx_q   <= '0;
                                        state_q <= S_LOAD;
                                    end else begin
                                        state_q <= S_DONE;
                                        done_q  <= 1'b1;
                                    end
                                end
                            end else begin
                                presc_q <= presc_q + PRE_W'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign note_index  = idx_q;
    assign note_start  = note_start_q;
    assign done        = done_q;
    assign note_active = (state_q == S_PLAY) || (state_q == S_PAUSED);
    assign busy        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_note_sequencer.sv
// ============================================================================
// Module   : tb_note_sequencer
// Purpose  : Directed self-checking bench for note_sequencer at 4 MHz
//            (4 cycles per microsecond) with a 3-bit index so index wrap
//            is reachable quickly.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_note_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        pause;
    logic        loop_en;
    logic [1:0]  speed;
    logic [23:0] dur_us;
    logic [2:0]  note_index;
    logic        note_active;
    logic        note_start;
    logic        done;
    logic        busy;

    logic [23:0] tbl [8];

    int total;
    int passed;
    int done_cnt;
    int ns_cnt;

    assign dur_us = tbl[note_index];

    note_sequencer #(
        .CLOCK_FREQ (4_000_000),
        .IDX_W      (3),
        .DUR_US_W   (24)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .loop_en     (loop_en),
        .speed       (speed),
        .dur_us      (dur_us),
        .note_index  (note_index),
        .note_active (note_active),
        .note_start  (note_start),
        .done        (done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (done) done_cnt++;
        if (note_start) ns_cnt++;
    endtask

    // Steps at least once, then until note_start or budget exhausted.
    task automatic wait_start(input string tag);
        int cyc;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!note_start && cyc < 500);
        check(tag, 32'(note_start), 32'd1);
    endtask

    task automatic count_active(output int n);
        n = 0;
        while (note_active && n < 2000) begin
            n++;
            step();
        end
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic set_tbl(input logic [23:0] a, input logic [23:0] b,
                           input logic [23:0] c);
        for (int i = 0; i < 8; i++) tbl[i] = 24'd0;
        tbl[0] = a;
        tbl[1] = b;
        tbl[2] = c;
    endtask

    initial begin
        int n;
        int d0;
        int n0;
        int cyc;
        int seq [4];

        total = 0; passed = 0; done_cnt = 0; ns_cnt = 0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        loop_en = 1'b0; speed = 2'd0;
        set_tbl(24'd3, 24'd5, 24'd0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // ---- reset state ----
        check("rst_idx", 32'(note_index), 32'd0);
        check("rst_active", 32'(note_active), 32'd0);
        check("rst_nstart", 32'(note_start), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // ---- stop wins over start in IDLE ----
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("stop_prio_busy", 32'(busy), 32'd0);

        // ---- basic playback {3,5,0} ----
        kick();
        check("t1_load_busy", 32'(busy), 32'd1);
        check("t1_load_active", 32'(note_active), 32'd0);
        wait_start("t1_ns0");
        check("t1_idx0", 32'(note_index), 32'd0);
        n0 = ns_cnt;
        count_active(n);
        check("t1_play0_cycles", 32'(n), 32'd12);
        check("t1_ns_single", 32'(ns_cnt - n0), 32'd0);
        check("t1_load1_idx", 32'(note_index), 32'd1);
        check("t1_load1_active", 32'(note_active), 32'd0);
        step();
        check("t1_ns1", 32'(note_start), 32'd1);
        count_active(n);
        check("t1_play1_cycles", 32'(n), 32'd20);
        step();
        check("t1_done", 32'(done), 32'd1);
        check("t1_done_busy", 32'(busy), 32'd1);
        check("t1_done_idx", 32'(note_index), 32'd2);
        step();
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_done", 32'(done), 32'd0);
        check("t1_idle_idx", 32'(note_index), 32'd2);

        // ---- looping {3,5,0} ----
        loop_en = 1'b1;
        d0 = done_cnt;
        kick();
        for (int i = 0; i < 4; i++) begin
            wait_start("t2_ns");
            seq[i] = 32'(note_index);
        end
        check("t2_seq0", 32'(seq[0]), 32'd0);
        check("t2_seq1", 32'(seq[1]), 32'd1);
        check("t2_seq2", 32'(seq[2]), 32'd0);
        check("t2_seq3", 32'(seq[3]), 32'd1);
        check("t2_no_done", 32'(done_cnt - d0), 32'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t2_stop_busy", 32'(busy), 32'd0);
        check("t2_stop_idx", 32'(note_index), 32'd0);
        check("t2_stop_active", 32'(note_active), 32'd0);
        check("t2_stop_done", 32'(done_cnt - d0), 32'd0);

        // ---- empty table, with and without loop ----
        set_tbl(24'd0, 24'd0, 24'd0);
        for (int l = 0; l < 2; l++) begin
            loop_en = (l == 1);
            n0 = ns_cnt;
            kick();
            step();
            check("t3_done", 32'(done), 32'd1);
            step();
            check("t3_idle", 32'(busy), 32'd0);
            check("t3_no_nstart", 32'(ns_cnt - n0), 32'd0);
        end

        // ---- pause {4,0}: 7 paused cycles from cycle 6 of the note ----
        loop_en = 1'b0;
        set_tbl(24'd4, 24'd0, 24'd0);
        kick();
        wait_start("t4_ns");
        n = 0;
        while (note_active && n < 2000) begin
            n++;
            if (n == 5) pause = 1'b1;
            if (n == 12) pause = 1'b0;
            step();
        end
        check("t4_active_cycles", 32'(n), 32'd23);
        check("t4_idx", 32'(note_index), 32'd1);
        step();
        check("t4_done", 32'(done), 32'd1);
        step();

        // ---- speed ----
        speed = 2'd1;
        set_tbl(24'd5, 24'd0, 24'd0);
        kick();
        wait_start("t5_ns2x");
        count_active(n);
`ifdef NOTE_SEQ_SPEED_EN
        check("t5_2x_cycles", 32'(n), 32'd12);
`else
        check("t5_2x_cycles", 32'(n), 32'd20);
`endif
        repeat (3) step();
        speed = 2'd2;
        set_tbl(24'd3, 24'd0, 24'd0);
        kick();
        wait_start("t5_nshalf");
        count_active(n);
`ifdef NOTE_SEQ_SPEED_EN
        check("t5_half_cycles", 32'(n), 32'd24);
`else
        check("t5_half_cycles", 32'(n), 32'd12);
`endif
        repeat (3) step();
        speed = 2'd0;

        // ---- index wrap, no loop: done with index held at 7 ----
        for (int i = 0; i < 8; i++) tbl[i] = 24'd1;
        n0 = ns_cnt;
        kick();
        cyc = 0;
        while (!done && cyc < 500) begin
            step();
            cyc++;
        end
        check("t6_wrap_done", 32'(done), 32'd1);
        check("t6_wrap_idx", 32'(note_index), 32'd7);
        check("t6_wrap_notes", 32'(ns_cnt - n0), 32'd8);
        step();
        check("t6_wrap_idle", 32'(busy), 32'd0);

        // ---- index wrap with loop: ninth note is index 0 ----
        loop_en = 1'b1;
        d0 = done_cnt;
        kick();
        for (int i = 0; i < 9; i++) wait_start("t7_ns");
        check("t7_wrap_idx", 32'(note_index), 32'd0);
        check("t7_no_done", 32'(done_cnt - d0), 32'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        loop_en = 1'b0;

        // ---- async reset mid-PLAY ----
        set_tbl(24'd3, 24'd5, 24'd0);
        kick();
        wait_start("t8_ns");
        repeat (4) step();
        rst_n = 1'b0;
        #2;
        check("t8_rst_active", 32'(note_active), 32'd0);
        check("t8_rst_busy", 32'(busy), 32'd0);
        check("t8_rst_idx", 32'(note_index), 32'd0);
        check("t8_rst_pulses", 32'({note_start, done}), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        kick();
        wait_start("t8_replay_ns");
        check("t8_replay_idx", 32'(note_index), 32'd0);
        count_active(n);
        check("t8_replay_cycles", 32'(n), 32'd12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
